// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with a valid/ready load side and a stallable
// serial side, so one word can follow another with no gap on x.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             x,
    output logic             x_valid,
    output logic             x_last
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : gWidthCheck
            $error("piso_serializer: WIDTH must be in 2..32");
        end
    endgenerate

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam int XBIT = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    typedef enum logic {
        IDLE,
        SHIFT
    } serState_t;

    serState_t        state_q, state_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             xLast_q, xLast_d;
    logic             loadReady;
    logic             handshake;

    // Ready also opens on the last bit of a word so the next word can chain in.
    always_comb begin
        loadReady = reset && ((state_q == IDLE) || (xLast_q && shift_en));
        handshake = load_valid && loadReady;
    end

    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        count_d    = count_q;
        xLast_d    = xLast_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d    = SHIFT;
                    shiftReg_d = load_data;
                    count_d    = '0;
                    xLast_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (xLast_q) begin
                        if (handshake) begin
                            shiftReg_d = load_data;
                            count_d    = '0;
                            xLast_d    = 1'b0;
                        end else begin
                            state_d    = IDLE;
                            shiftReg_d = '0;
                            count_d    = '0;
                            xLast_d    = 1'b0;
                        end
                    end else begin
                        if (MSB_FIRST != 0) begin
                            shiftReg_d = {shiftReg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shiftReg_d = {1'b0, shiftReg_q[WIDTH-1:1]};
                        end
                        count_d = count_q + 1'b1;
                        xLast_d = ((count_q + 1'b1) == LAST_CNT);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                shiftReg_d = '0;
                count_d    = '0;
                xLast_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            count_q    <= '0;
            xLast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            count_q    <= count_d;
            xLast_q    <= xLast_d;
        end
    end

    // The shift register is zeroed whenever the machine is idle, so x reads 0 there.
    always_comb begin
        load_ready = loadReady;
        x          = shiftReg_q[XBIT];
        x_valid    = (state_q == SHIFT);
        x_last     = xLast_q;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an MSB-first and an LSB-first serializer with shared stimulus and
// scoreboards both against a queue-of-bits reference model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         loadValid;
    logic [W-1:0] loadData;
    logic         shiftEn;
    logic [1:0]   loadReady;
    logic [1:0]   xOut;
    logic [1:0]   xValid;
    logic [1:0]   xLast;

    logic [1:0]   expQ [2][$];
    bit           monOn = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dutMsb (
        .clk(clk), .reset(reset), .load_valid(loadValid), .load_data(loadData),
        .load_ready(loadReady[0]), .shift_en(shiftEn), .x(xOut[0]),
        .x_valid(xValid[0]), .x_last(xLast[0])
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dutLsb (
        .clk(clk), .reset(reset), .load_valid(loadValid), .load_data(loadData),
        .load_ready(loadReady[1]), .shift_en(shiftEn), .x(xOut[1]),
        .x_valid(xValid[1]), .x_last(xLast[1])
    );

    task automatic checkOutput(input string name, input int dut, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s dut=%0d t=%0t actual=%b expected=%b", name, dut, $time, actual, expected);
        end
    endtask

    // Inputs change just after the rising edge and stay put until the next one.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic se, input logic rst);
        @(posedge clk);
        #1;
        loadValid = v;
        loadData  = d;
        shiftEn   = se;
        reset     = rst;
    endtask

    // Reference: each accepted word becomes W expected {last,bit} entries in order.
    always @(negedge clk) begin
        if (monOn) begin
            for (int d = 0; d < 2; d++) begin
                logic expValid;
                logic expReady;
                int   qs;
                qs       = expQ[d].size();
                expValid = (qs > 0);
                checkOutput("x_valid", d, xValid[d], expValid);
                if (expValid) begin
                    checkOutput("x", d, xOut[d], expQ[d][0][0]);
                    checkOutput("x_last", d, xLast[d], expQ[d][0][1]);
                end else begin
                    checkOutput("x_idle", d, xOut[d], 1'b0);
                    checkOutput("x_last_idle", d, xLast[d], 1'b0);
                end
                expReady = reset && ((qs == 0) || (qs == 1 && shiftEn));
                checkOutput("load_ready", d, loadReady[d], expReady);
                if (!reset) begin
                    expQ[d].delete();
                end else begin
                    if (expValid && shiftEn) void'(expQ[d].pop_front());
                    if (loadValid && expReady) begin
                        for (int k = 0; k < W; k++) begin
                            logic b;
                            b = (d == 0) ? loadData[W-1-k] : loadData[k];
                            expQ[d].push_back({(k == W - 1), b});
                        end
                    end
                end
            end
        end
    end

    initial begin
        loadValid = 1'b0;
        loadData  = '0;
        shiftEn   = 1'b1;
        reset     = 1'b0;
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        monOn = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

        $display("[TB] single word 8'hB5");
        applyStimulus(1'b1, 8'hB5, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

        $display("[TB] back-to-back 8'h0B then 8'hB0");
        applyStimulus(1'b1, 8'h0B, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hB0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

        $display("[TB] stall on 8'hFF");
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

        $display("[TB] 8'h0D");
        applyStimulus(1'b1, 8'h0D, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

        $display("[TB] reset mid-word on 8'hAA");
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

        $display("[TB] load attempts while busy");
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, W'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, W'($urandom), 1'b1, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), W'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) != 0));
        end

        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("drain_msb", 0, (expQ[0].size() == 0), 1'b1);
        checkOutput("drain_lsb", 1, (expQ[1].size() == 0), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
